// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encodings, default line parameters
// and the oversample divider calculation. The defaults match the TX side so
// both ends agree on CLK_FREQ and BAUD_RATE.
`timescale 1ns/1ps
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
    localparam int unsigned DEF_BAUD_RATE  = 9600;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Clocks per sample tick, truncated (651 at the defaults).
    function automatic int unsigned os_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the raw rx pin plus the receiver's result signals.
// master: the side driving the line and consuming results (board / bench).
// slave : the receiver itself.
`timescale 1ns/1ps
interface uart_rx_if;
    logic       rx;         // asynchronous serial input, idle high
    logic [7:0] rx_data;    // last correctly framed byte
    logic       rx_done;    // 1-cycle strobe, rx_data valid in that cycle
    logic       rx_busy;    // receiver is not idle
    logic       frame_err;  // 1-cycle strobe, stop bit sampled 0

    modport master (output rx, input  rx_data, rx_done, rx_busy, frame_err);
    modport slave  (input  rx, output rx_data, rx_done, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx_os_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, s_tick_o high for
// the one clk in which the count wraps. Never resynchronised to the line.
// Ports: clk, reset (sync, active-high) -> s_tick_o.
`timescale 1ns/1ps
module uart_rx_os_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic s_tick_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign s_tick_o = (cnt_q == LAST);
    assign cnt_d    = s_tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x (OVERSAMPLE) oversampling of a 2-flop
// synchronised rx pin. Emits rx_done with rx_data, or frame_err, 1 clk each.
// Ports: clk, reset (sync, active-high), bus (uart_rx_if.slave).
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE   // even, >= 8
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus
);
    localparam int unsigned DIV = os_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    // Decision points: half a bit into the start bit, then one full bit each.
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic            s_tick;
    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_e       state_q;
    logic [SW-1:0]   s_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [7:0]      rx_data_q;
    logic            rx_done_q;
    logic            frame_err_q;
    logic            rx_busy_q;

    uart_rx_os_tick #(.DIV(DIV)) u_os_tick (
        .clk      (clk),
        .reset    (reset),
        .s_tick_o (s_tick)
    );

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // rx_busy_q is updated on every state change so it always equals (state != IDLE).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= START;
                        s_cnt_q   <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt_q == S_MID) begin
                            if (!rx_s_q) begin
                                state_q   <= DATA;
                                s_cnt_q   <= '0;
                                bit_cnt_q <= '0;
                            end else begin
                                // Line back high by mid start bit: glitch, drop it.
                                state_q   <= IDLE;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt_q == S_LAST) begin
                            shreg_q <= {rx_s_q, shreg_q[7:1]};
                            s_cnt_q <= '0;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt_q == S_LAST) begin
                            if (rx_s_q) begin
                                rx_data_q <= shreg_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            // Leave at mid stop bit so a back-to-back start edge is caught.
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.rx_busy   = rx_busy_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
    // Fast line rate so a frame is 640 clk: DIV = 100e6/(1_562_500*16) = 4.
    localparam int unsigned CLK_FREQ = 100_000_000;
    localparam int unsigned BAUD     = 1_562_500;
    localparam int unsigned OS       = 16;
    localparam int unsigned DIV      = CLK_FREQ / (BAUD * OS);
    localparam real         BIT_NS   = 1.0e9 / BAUD;   // 640 ns

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a line frame with stop=1 delivers its byte, stop=0 gives one error.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_ferr  = 0;
    int         got_ferr  = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_done) got_q.push_back(bus.rx_data);
            if (bus.frame_err) got_ferr++;
            if (bus.rx_done && bus.frame_err) check_eq("done_and_ferr", 1, 0);
            if (bus.rx_done && prev_done) check_eq("done_width", 2, 1);
            prev_done = bus.rx_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic idle_bits(input real n);
        bus.rx = 1'b1;
        #(n * BIT_NS);
    endtask

    // Behavioural transmitter. A bad stop bit is held low for 3/4 bit so the
    // receiver's re-armed start check lands on the idle-high line.
    task automatic send_frame(input logic [7:0] d, input real bit_ns, input bit stop_ok);
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            #(bit_ns);
        end
        if (stop_ok) begin
            bus.rx = 1'b1;
            exp_q.push_back(d);
            last_good = d;
            #(bit_ns);
        end else begin
            bus.rx = 1'b0;
            exp_ferr++;
            #(bit_ns * 0.75);
            bus.rx = 1'b1;
            #(bit_ns * 0.25);
        end
    endtask

    task automatic compare_stream(input string tag);
        @(negedge clk);
        check_eq({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq({tag, " byte"}, got_q[i], exp_q[i]);
        end
        check_eq({tag, " ferr"}, got_ferr, exp_ferr);
        check_eq({tag, " rx_data"}, bus.rx_data, last_good);
        check_eq({tag, " busy"}, bus.rx_busy, 0);
        exp_q.delete();
        got_q.delete();
        exp_ferr = 0;
        got_ferr = 0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b81;
        logic [7:0] b;
        real        skew;
        bit         ok;

        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("reset rx_data", bus.rx_data, 8'h00);
        check_eq("reset rx_done", bus.rx_done, 0);
        check_eq("reset rx_busy", bus.rx_busy, 0);
        check_eq("reset frame_err", bus.frame_err, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_bits(2);

        // Single frame
        send_frame(8'hA5, BIT_NS, 1'b1);
        idle_bits(2);
        compare_stream("loopback");

        // Short low pulse of 3 sample ticks
        bus.rx = 1'b0;
        #(3 * DIV * 10);
        idle_bits(2);
        compare_stream("glitch");

        // Stop bit forced low
        send_frame(8'h3C, BIT_NS, 1'b0);
        idle_bits(2);
        compare_stream("framing");

        // Back-to-back frames
        send_frame(8'h00, BIT_NS, 1'b1);
        send_frame(8'hFF, BIT_NS, 1'b1);
        send_frame(8'h55, BIT_NS, 1'b1);
        idle_bits(2);
        compare_stream("b2b");

        // Reset during data bit 4 of 8'h81
        b81 = 8'h81;
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b81[i];
            #(BIT_NS);
        end
        bus.rx = b81[4];
        #(BIT_NS / 2);
        check_eq("midframe busy", bus.rx_busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst rx_data", bus.rx_data, 8'h00);
        check_eq("rst rx_done", bus.rx_done, 0);
        check_eq("rst rx_busy", bus.rx_busy, 0);
        check_eq("rst frame_err", bus.frame_err, 0);
        @(negedge clk);
        reset     = 1'b0;
        last_good = 8'h00;
        idle_bits(6);
        send_frame(8'h7E, BIT_NS, 1'b1);
        idle_bits(2);
        compare_stream("after_reset");

        // Transmitter baud skew +/-3%
        send_frame(8'hC3, BIT_NS / 1.03, 1'b1);
        idle_bits(2);
        compare_stream("skew_fast");
        send_frame(8'hC3, BIT_NS / 0.97, 1'b1);
        idle_bits(2);
        compare_stream("skew_slow");

        // Random stream: skewed good frames, nominal-rate bad frames with a gap after
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            ok   = ($urandom_range(0, 5) != 0);
            skew = 0.975 + real'($urandom_range(0, 50)) / 1000.0;
            if (ok) begin
                send_frame(b, BIT_NS / skew, 1'b1);
                idle_bits(real'($urandom_range(0, 2)));
            end else begin
                send_frame(b, BIT_NS, 1'b0);
                idle_bits(real'($urandom_range(1, 2)));
            end
        end
        idle_bits(2);
        compare_stream("random");

        d = bus.rx_data;
        check_eq("final rx_data", d, last_good);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
